// File: rtl/instruction_fetch_queue.sv
// Instruction fetch stage with a DEPTH-entry prefetch queue of {pc, instr} pairs.
// Sequential requests use a level syn/ack handshake, and a PC redirect flushes the queue.
module instruction_fetch_queue #(
    parameter int                  IWIDTH   = 32,
    parameter int                  AWIDTH   = 32,
    parameter int                  PC_WIDTH = 32,
    parameter int                  DEPTH    = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int                  PC_STEP  = 4,
    parameter int                  CWIDTH   = $clog2(DEPTH) + 1
) (
    input  logic                f_clk,
    input  logic                f_rst,
    output logic [AWIDTH-1:0]   f_o_addr_instr,
    output logic                f_o_syn,
    input  logic                f_i_ack,
    input  logic [IWIDTH-1:0]   f_i_instr,
    input  logic                f_change_pc,
    input  logic [PC_WIDTH-1:0] f_alu_pc_value,
    output logic                f_o_ce,
    output logic [IWIDTH-1:0]   f_o_instr,
    output logic [PC_WIDTH-1:0] f_pc,
    input  logic                f_i_stall,
    output logic [CWIDTH-1:0]   f_o_count
);

    localparam int PWIDTH = $clog2(DEPTH);

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [IWIDTH-1:0]   instr;
    } entry_t;

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                syn_q, syn_d;
    logic [PWIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PWIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CWIDTH-1:0]   count_q, count_d;
    entry_t              mem_q [DEPTH];
    entry_t              mem_d [DEPTH];
    logic                push;
    logic                pop;
    entry_t              head;

    // A redirect suppresses both the push of a coincident ack and any pop.
    assign push = syn_q && f_i_ack && !f_change_pc;
    assign pop  = (count_q != '0) && !f_i_stall && !f_change_pc;
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        pc_d     = pc_q;
        syn_d    = syn_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (f_change_pc) begin
            pc_d     = f_alu_pc_value;
            syn_d    = 1'b1;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{pc: pc_q, instr: f_i_instr};
                wr_ptr_d        = wr_ptr_q + PWIDTH'(1);
                pc_d            = pc_q + PC_WIDTH'(PC_STEP);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PWIDTH'(1);
            end
            count_d = count_q + CWIDTH'(push) - CWIDTH'(pop);
            // Request only while the post-edge queue still has a free slot.
            syn_d   = (count_d < CWIDTH'(DEPTH));
        end
    end

    always_ff @(posedge f_clk or posedge f_rst) begin
        if (f_rst) begin
            pc_q     <= RESET_PC;
            syn_q    <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            syn_q    <= syn_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage holds no reset; entries are only observed once counted as valid.
    always_ff @(posedge f_clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        f_o_addr_instr = pc_q[AWIDTH-1:0];
        f_o_syn        = syn_q;
        f_o_count      = count_q;
        f_o_ce         = (count_q != '0);
        f_o_instr      = '0;
        f_pc           = '0;
        if (f_o_ce) begin
            f_o_instr = head.instr;
            f_pc      = head.pc;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench for instruction_fetch_queue: directed table, corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_instruction_fetch_queue;

    logic        f_clk = 1'b0;
    logic        f_rst = 1'b1;
    logic        f_i_ack = 1'b0;
    logic [31:0] f_i_instr = '0;
    logic        f_change_pc = 1'b0;
    logic [31:0] f_alu_pc_value = '0;
    logic        f_i_stall = 1'b0;
    logic [31:0] f_o_addr_instr;
    logic        f_o_syn;
    logic        f_o_ce;
    logic [31:0] f_o_instr;
    logic [31:0] f_pc;
    logic [2:0]  f_o_count;

    // Second instance exercises PC wrap from a high reset PC.
    logic        w_ack = 1'b0;
    logic [31:0] w_instr_i = '0;
    logic        w_stall = 1'b1;
    logic [31:0] w_addr;
    logic        w_syn;
    logic        w_ce;
    logic [31:0] w_instr_o;
    logic [31:0] w_pc;
    logic [2:0]  w_cnt;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] m_pc;
    logic        m_syn;

    typedef struct {
        logic        ack;
        logic [31:0] instr;
        logic        stall;
        logic        e_syn;
        logic [31:0] e_addr;
        logic        e_ce;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[5];

    always #5 f_clk = ~f_clk;

    instruction_fetch_queue dut (
        .f_clk(f_clk), .f_rst(f_rst),
        .f_o_addr_instr(f_o_addr_instr), .f_o_syn(f_o_syn),
        .f_i_ack(f_i_ack), .f_i_instr(f_i_instr),
        .f_change_pc(f_change_pc), .f_alu_pc_value(f_alu_pc_value),
        .f_o_ce(f_o_ce), .f_o_instr(f_o_instr), .f_pc(f_pc),
        .f_i_stall(f_i_stall), .f_o_count(f_o_count)
    );

    instruction_fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .f_clk(f_clk), .f_rst(f_rst),
        .f_o_addr_instr(w_addr), .f_o_syn(w_syn),
        .f_i_ack(w_ack), .f_i_instr(w_instr_i),
        .f_change_pc(1'b0), .f_alu_pc_value(32'h0),
        .f_o_ce(w_ce), .f_o_instr(w_instr_o), .f_pc(w_pc),
        .f_i_stall(w_stall), .f_o_count(w_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc  = 32'h0;
        m_syn = 1'b0;
    endtask

    // Reference behaviour: flush on redirect, otherwise pop head if allowed and append on handshake.
    task automatic model_edge(input logic ack, input logic [31:0] instr, input logic stall,
                              input logic chg, input logic [31:0] tgt);
        bit do_pop;
        bit do_push;
        if (chg) begin
            mq.delete();
            m_pc  = tgt;
            m_syn = 1'b1;
        end else begin
            do_pop  = (mq.size() != 0) && !stall;
            do_push = m_syn && ack;
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back('{pc: m_pc, instr: instr});
                m_pc = m_pc + 32'd4;
            end
            m_syn = (mq.size() < 4);
        end
    endtask

    task automatic compare_model();
        check("syn", 64'(f_o_syn), 64'(m_syn));
        check("addr", 64'(f_o_addr_instr), 64'(m_pc));
        check("count", 64'(f_o_count), 64'(mq.size()));
        check("ce", 64'(f_o_ce), 64'(mq.size() != 0));
        check("head_pc", 64'(f_pc), (mq.size() != 0) ? 64'(mq[0].pc) : 64'h0);
        check("head_instr", 64'(f_o_instr), (mq.size() != 0) ? 64'(mq[0].instr) : 64'h0);
    endtask

    task automatic tick(input logic ack, input logic [31:0] instr, input logic stall,
                        input logic chg, input logic [31:0] tgt);
        f_i_ack        = ack;
        f_i_instr      = instr;
        f_i_stall      = stall;
        f_change_pc    = chg;
        f_alu_pc_value = tgt;
        @(posedge f_clk);
        model_edge(ack, instr, stall, chg, tgt);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        f_rst = 1'b1;
        f_i_ack = 1'b0;
        f_change_pc = 1'b0;
        f_i_stall = 1'b0;
        w_ack = 1'b0;
        w_stall = 1'b1;
        @(posedge f_clk);
        @(posedge f_clk);
        #1;
        f_rst = 1'b0;
        model_reset();
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0,        3'd0};
        vecs[1] = '{1'b1, 32'hA0A0A0A0, 1'b0, 1'b1, 32'h4, 1'b1, 32'h0, 32'hA0A0A0A0, 3'd1};
        vecs[2] = '{1'b1, 32'hB1B1B1B1, 1'b0, 1'b1, 32'h8, 1'b1, 32'h4, 32'hB1B1B1B1, 3'd1};
        vecs[3] = '{1'b1, 32'hC2C2C2C2, 1'b0, 1'b1, 32'hC, 1'b1, 32'h8, 32'hC2C2C2C2, 3'd1};
        vecs[4] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'hC, 1'b0, 32'h0, 32'h0,        3'd0};

        do_reset();
        check("rst_syn", 64'(f_o_syn), 64'h0);
        check("rst_addr", 64'(f_o_addr_instr), 64'h0);
        check("rst_ce", 64'(f_o_ce), 64'h0);
        check("rst_cnt", 64'(f_o_count), 64'h0);
        check("rst_wrap_addr", 64'(w_addr), 64'hFFFF_FFF8);

        foreach (vecs[i]) begin
            tick(vecs[i].ack, vecs[i].instr, vecs[i].stall, 1'b0, 32'h0);
            check($sformatf("v%0d_syn", i), 64'(f_o_syn), 64'(vecs[i].e_syn));
            check($sformatf("v%0d_addr", i), 64'(f_o_addr_instr), 64'(vecs[i].e_addr));
            check($sformatf("v%0d_ce", i), 64'(f_o_ce), 64'(vecs[i].e_ce));
            check($sformatf("v%0d_pc", i), 64'(f_pc), 64'(vecs[i].e_pc));
            check($sformatf("v%0d_instr", i), 64'(f_o_instr), 64'(vecs[i].e_instr));
            check($sformatf("v%0d_cnt", i), 64'(f_o_count), 64'(vecs[i].e_cnt));
        end

        // Stall until full, then a single pop reopens the request.
        do_reset();
        tick(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) tick(1'b1, 32'h1000 + 32'(i), 1'b1, 1'b0, 32'h0);
        check("full_cnt", 64'(f_o_count), 64'd4);
        check("full_syn", 64'(f_o_syn), 64'h0);
        check("full_addr", 64'(f_o_addr_instr), 64'h10);
        check("full_head", 64'(f_pc), 64'h0);
        tick(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("pop_cnt", 64'(f_o_count), 64'd3);
        check("pop_syn", 64'(f_o_syn), 64'h1);
        check("pop_addr", 64'(f_o_addr_instr), 64'h10);

        // Withheld ack keeps the request stable.
        for (int i = 0; i < 3; i++) tick(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("wait_addr", 64'(f_o_addr_instr), 64'h10);
        check("wait_cnt", 64'(f_o_count), 64'd3);
        tick(1'b1, 32'h5555, 1'b1, 1'b0, 32'h0);
        check("late_ack_cnt", 64'(f_o_count), 64'd4);

        // Redirect coincident with ack and stall on a partly filled queue.
        do_reset();
        tick(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) tick(1'b1, 32'h2000 + 32'(i), 1'b1, 1'b0, 32'h0);
        tick(1'b1, 32'hDEAD, 1'b1, 1'b1, 32'h100);
        check("redir_cnt", 64'(f_o_count), 64'd0);
        check("redir_ce", 64'(f_o_ce), 64'h0);
        check("redir_addr", 64'(f_o_addr_instr), 64'h100);
        tick(1'b1, 32'hE4E4E4E4, 1'b1, 1'b0, 32'h0);
        check("redir_pc", 64'(f_pc), 64'h100);
        check("redir_instr", 64'(f_o_instr), 64'hE4E4E4E4);

        // Asynchronous reset in the middle of a cycle.
        tick(1'b1, 32'h3333, 1'b1, 1'b0, 32'h0);
        #3 f_rst = 1'b1;
        #1;
        check("arst_syn", 64'(f_o_syn), 64'h0);
        check("arst_ce", 64'(f_o_ce), 64'h0);
        check("arst_cnt", 64'(f_o_count), 64'h0);
        check("arst_addr", 64'(f_o_addr_instr), 64'h0);
        check("arst_pc", 64'(f_pc), 64'h0);
        check("arst_instr", 64'(f_o_instr), 64'h0);
        #1 f_rst = 1'b0;
        model_reset();
        tick(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 19) == 0), $urandom & 32'hFFFF_FFFC);
        end

        // PC wrap on the second instance.
        do_reset();
        tick(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        w_ack = 1'b1;
        w_instr_i = 32'h7777_0001;
        @(posedge f_clk);
        #1;
        check("wrap_pc0", 64'(w_pc), 64'hFFFF_FFF8);
        check("wrap_addr1", 64'(w_addr), 64'hFFFF_FFFC);
        w_instr_i = 32'h7777_0002;
        @(posedge f_clk);
        #1;
        check("wrap_addr2", 64'(w_addr), 64'h0);
        check("wrap_cnt", 64'(w_cnt), 64'd2);
        w_ack = 1'b0;
        w_stall = 1'b0;
        @(posedge f_clk);
        #1;
        check("wrap_pc1", 64'(w_pc), 64'hFFFF_FFFC);
        check("wrap_instr1", 64'(w_instr_o), 64'h7777_0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

Parametrised successor to the single-slot instruction fetch stage. It streams sequential instruction-memory requests through a level syn/ack handshake into a DEPTH-entry prefetch queue that holds {pc, instr} pairs. It presents the queue head to decode with a stall input and flushes everything on a PC redirect. It sits between instruction memory and the decode stage.

## Interface
- IWIDTH, 32, instruction width
- AWIDTH, 32, instruction-memory address width
- PC_WIDTH, 32, program counter width (must be ≥ AWIDTH)
- DEPTH, 4, queue entries; power of two, ≥ 2
- RESET_PC, 0, fetch PC after reset
- PC_STEP, 4, sequential PC increment
- CWIDTH, $clog2(DEPTH)+1, occupancy counter width (derived)

Ports:
- f_clk  in  1  clock, rising edge
- f_rst  in  1  asynchronous, active-high reset
- f_o_addr_instr  out  AWIDTH  request address, low AWIDTH bits of fetch PC
- f_o_syn  out  1  request valid
- f_i_ack  in  1  memory response valid; f_i_instr is valid with it
- f_i_instr  in  IWIDTH  fetched instruction
- f_change_pc  in  1  redirect strobe
- f_alu_pc_value  in  PC_WIDTH  redirect target
- f_o_ce  out  1  head entry valid
- f_o_instr  out  IWIDTH  head instruction
- f_pc  out  PC_WIDTH  PC of head instruction
- f_i_stall  in  1  decode not ready; holds the head
- f_o_count  out  CWIDTH  queue occupancy, 0..DEPTH

## Operation
- State: fetch PC register, syn register, DEPTH-entry storage, rd/wr pointers (log2 DEPTH bits, wrap modulo DEPTH), count.
- Transfer: occurs on an edge where f_o_syn && f_i_ack.
  - Pushes {fetch PC, f_i_instr} at wr pointer.
  - Fetch PC advances by PC_STEP, modulo 2^PC_WIDTH.
- While f_o_syn=1 and no ack arrives, f_o_addr_instr is held stable.
- At most one request is outstanding. Memory may hold ack low any number of cycles.
- Pop: occurs on an edge where f_o_ce && !f_i_stall && !f_change_pc. Advances rd pointer.
- count_next = count + push − pop. A simultaneous push and pop leaves count unchanged.
- f_o_syn_next = (count_next < DEPTH). Syn is never high when count == DEPTH, so the queue cannot overflow.
- Redirect: on an edge with f_change_pc=1:
  - pointers and count clear to 0;
  - fetch PC loads f_alu_pc_value;
  - f_o_syn becomes 1;
  - any ack on that edge is discarded (no push);
  - no pop occurs;
  - f_i_stall is ignored.
- Outputs:
  - f_o_ce = (count != 0).
  - When f_o_ce=1: f_o_instr/f_pc = head entry.
  - When f_o_ce=0: f_o_instr and f_pc are forced to 0.
  - f_o_count = count.

## Timing
- Reset values: f_o_syn=0, f_o_addr_instr=RESET_PC[AWIDTH-1:0], f_o_ce=0, f_o_instr=0, f_pc=0, f_o_count=0, pointers 0. Storage contents are don't-care.
- Reset mid-operation clears all state immediately, regardless of the clock. Any in-flight request is abandoned.
- First edge after reset deasserts: f_o_syn rises to 1 at RESET_PC.
- Latency: ack sampled at edge k gives f_o_ce=1 with that entry from edge k (visible in cycle k+1). The address advances at the same edge.
- Throughput: 1 instr/cycle when ack is high every cycle and decode does not stall.
- Full, no pop: syn=0 and the address holds.
  - A pop at edge k makes count_next=DEPTH−1, so syn=1 again from edge k.
- Stall with an empty queue: has no effect. Fetch continues until full.
- Redirect at edge k: f_o_ce=0 and the address equals the target in cycle k+1. The first post-redirect instruction is valid one edge after its ack.
- Redirect coincident with full, stall, or ack: the redirect wins over everything.
- PC wrap: the increment from 2^PC_WIDTH − PC_STEP goes to 0. No flag is raised.

## Test plan
- Reset, then ack every cycle with A0A0A0A0, B1B1B1B1, C2C2C2C2, no stall:
  - addresses 0, 4, 8 on consecutive cycles;
  - f_o_ce high from the first ack+1;
  - f_pc/f_o_instr = 0/A0A0A0A0, 4/B1B1B1B1, 8/C2C2C2C2.
- Stall held with acks every cycle, DEPTH=4:
  - count reaches 4; syn drops; address holds at 0x10;
  - head stays pc 0.
  - Release stall for one cycle: one pop, count=3, syn high again at 0x10.
- Ack withheld for 3 cycles: syn stays 1, address stable, count unchanged. Ack then pushes exactly one entry.
- Redirect to 0x100 with 3 entries queued and ack high on the same edge:
  - next cycle count=0, f_o_ce=0, address 0x100;
  - no stale entry appears;
  - next ack with E4E4E4E4 gives f_pc=0x100.
- Async reset asserted mid-cycle with the queue half full: all outputs reach their reset values before the next edge.
- RESET_PC = 0xFFFFFFF8, two acks: pc sequence FFFFFFF8, FFFFFFFC, then address 0.
